sequence_checker: RTL and testbench

Downstream of the seven-segment sequence entry stage. Latches the 16-bit target sequence when the controller enters the entry game state, then samples the user's 4-bit code once per digit confirmation, compares each sampled nibble against the matching target nibble, and enforces an entry time limit. It returns a single pass/fail verdict to the controller.

---
 rtl/sequence_checker_if.sv | 36 +++
 rtl/sequence_checker.sv | 164 ++++++++++++++++
 tb/tb_sequence_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_checker_if.sv
// rtl/sequence_checker_if.sv - controller-side bundle of the sequence checker
// Purpose: groups the game-state, entry and verdict signals between the
//   controller/entry stage (master) and the sequence checker (slave).
// Signals:
//   game_state     [7:0]  controller game state
//   sequence_in    [15:0] target sequence, digit 0 in [15:12]
//   user_code      [3:0]  current user code
//   button_next           one-cycle digit-confirm pulse
//   one_sec               one-cycle pulse per second
//   result_valid          one-cycle verdict-ready pulse
//   result_pass           verdict, held until re-armed
//   digit_index    [1:0]  next digit to be confirmed
//   mismatch_count [2:0]  mismatched digits so far
//   secs_left      [5:0]  remaining entry seconds
interface sequence_checker_if;
  logic [7:0]  game_state;
  logic [15:0] sequence_in;
  logic [3:0]  user_code;
  logic        button_next;
  logic        one_sec;
  logic        result_valid;
  logic        result_pass;
  logic [1:0]  digit_index;
  logic [2:0]  mismatch_count;
  logic [5:0]  secs_left;

  modport master (
    output game_state, sequence_in, user_code, button_next, one_sec,
    input  result_valid, result_pass, digit_index, mismatch_count, secs_left
  );

  modport slave (
    input  game_state, sequence_in, user_code, button_next, one_sec,
    output result_valid, result_pass, digit_index, mismatch_count, secs_left
  );
endinterface

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - checks a 4-digit user entry against a latched target
// Purpose: arms on ENTRY_STATE, shows the target for SHOW_SECS seconds,
//   collects four confirmed digits within TIME_LIMIT seconds and returns a
//   single registered pass/fail verdict.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-low reset
//   bus    - sequence_checker_if.slave (entry inputs, verdict outputs)
module sequence_checker #(
  parameter int          SHOW_SECS   = 3,
  parameter int          TIME_LIMIT  = 20,
  parameter logic [7:0]  ENTRY_STATE = 8'h10
) (
  input  logic               clk,
  input  logic               reset,
  sequence_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHOW, COLLECT, DONE} state_t;

  localparam logic [7:0] SHOW_LAST = 8'(SHOW_SECS - 1);
  localparam logic [5:0] LIMIT     = 6'(TIME_LIMIT);

  state_t      state, state_next;
  logic [15:0] target, target_next;
  logic [7:0]  show_cnt, show_cnt_next;
  logic        valid, valid_next;
  logic        pass, pass_next;
  logic [1:0]  digit, digit_next;
  logic [2:0]  mm, mm_next;
  logic [5:0]  secs, secs_next;
  logic        timeout, timeout_next;

  logic        armed;
  logic [3:0]  expected_nib;
  logic        final_digit;

  assign armed = (bus.game_state == ENTRY_STATE);

  always_comb begin
    case (digit)
      2'd0:    expected_nib = target[15:12];
      2'd1:    expected_nib = target[11:8];
      2'd2:    expected_nib = target[7:4];
      default: expected_nib = target[3:0];
    endcase
  end

  always_comb begin
    state_next    = state;
    target_next   = target;
    show_cnt_next = show_cnt;
    valid_next    = 1'b0;
    pass_next     = pass;
    digit_next    = digit;
    mm_next       = mm;
    secs_next     = secs;
    timeout_next  = timeout;
    final_digit   = 1'b0;

    case (state)
      IDLE: begin
        if (armed) begin
          target_next   = bus.sequence_in;
          show_cnt_next = 8'd0;
          pass_next     = 1'b0;
          timeout_next  = 1'b0;
          digit_next    = 2'd0;
          mm_next       = 3'd0;
          secs_next     = 6'd0;
          state_next    = SHOW;
        end
      end

      SHOW: begin
        if (!armed) begin
          state_next    = IDLE;
          show_cnt_next = 8'd0;
          pass_next     = 1'b0;
        end else if (bus.one_sec) begin
          if (show_cnt == SHOW_LAST) begin
            show_cnt_next = 8'd0;
            secs_next     = LIMIT;
            state_next    = COLLECT;
          end else begin
            show_cnt_next = show_cnt + 8'd1;
          end
        end
      end

      COLLECT: begin
        if (!armed) begin
          state_next   = IDLE;
          digit_next   = 2'd0;
          mm_next      = 3'd0;
          secs_next    = 6'd0;
          timeout_next = 1'b0;
          pass_next    = 1'b0;
        end else begin
          final_digit = bus.button_next && (digit == 2'd3);
          if (bus.button_next) begin
            digit_next = digit + 2'd1;
            if (bus.user_code != expected_nib)
              mm_next = mm + 3'd1;
          end
          if (bus.one_sec)
            secs_next = secs - 6'd1;
          // The last digit beats an expiring second in the same cycle.
          if (final_digit) begin
            state_next = DONE;
            valid_next = 1'b1;
            pass_next  = (mm_next == 3'd0) && !timeout;
          end else if (bus.one_sec && secs == 6'd1) begin
            state_next   = DONE;
            valid_next   = 1'b1;
            pass_next    = 1'b0;
            timeout_next = 1'b1;
          end
        end
      end

      default: begin
        // DONE: verdict holds through the return to IDLE until re-armed.
        if (!armed) begin
          state_next = IDLE;
          digit_next = 2'd0;
          mm_next    = 3'd0;
          secs_next  = 6'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      target   <= 16'd0;
      show_cnt <= 8'd0;
      valid    <= 1'b0;
      pass     <= 1'b0;
      digit    <= 2'd0;
      mm       <= 3'd0;
      secs     <= 6'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      show_cnt <= show_cnt_next;
      valid    <= valid_next;
      pass     <= pass_next;
      digit    <= digit_next;
      mm       <= mm_next;
      secs     <= secs_next;
      timeout  <= timeout_next;
    end
  end

  assign bus.result_valid   = valid;
  assign bus.result_pass    = pass;
  assign bus.digit_index    = digit;
  assign bus.mismatch_count = mm;
  assign bus.secs_left      = secs;

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - self-checking bench for sequence_checker
module tb_sequence_checker;
  localparam int SHOW = 3;
  localparam int LIM  = 4;
  localparam int N    = 80;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sequence_checker_if bus();

  sequence_checker #(.SHOW_SECS(SHOW), .TIME_LIMIT(LIM), .ENTRY_STATE(8'h10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        r;
    logic [7:0]  g;
    logic [15:0] sq;
    logic [3:0]  c;
    logic        b;
    logic        o;
    logic        ev;
    logic        ep;
    logic [1:0]  ed;
    logic [2:0]  em;
    logic [5:0]  es;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] g, input logic [15:0] sq,
                      input logic [3:0] c, input logic b, input logic o);
    reset           = r;
    bus.game_state  = g;
    bus.sequence_in = sq;
    bus.user_code   = c;
    bus.button_next = b;
    bus.one_sec     = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int v, input int p, input int d,
                         input int m, input int s);
    chk({nm, ".valid"}, int'(bus.result_valid), v);
    chk({nm, ".pass"},  int'(bus.result_pass), p);
    chk({nm, ".digit"}, int'(bus.digit_index), d);
    chk({nm, ".mm"},    int'(bus.mismatch_count), m);
    chk({nm, ".secs"},  int'(bus.secs_left), s);
  endtask

  task automatic arm(input logic [15:0] sq);
    step(1, 8'h10, sq, 4'h0, 0, 0);
    for (int i = 0; i < SHOW; i++) step(1, 8'h10, 16'h0, 4'h0, 0, 1);
  endtask

  // Random session arrays and model results
  bit          osa[N];
  bit          bna[N];
  logic [3:0]  uca[N];

  function automatic logic [3:0] nib(input logic [15:0] t, input int j);
    logic [15:0] sh;
    sh = t >> (12 - 4 * j);
    return sh[3:0];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.game_state = 8'h0; bus.sequence_in = 16'h0; bus.user_code = 4'h0;
    bus.button_next = 1'b0; bus.one_sec = 1'b0;

    tbl[0]  = '{0, 8'h00, 16'h0000, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[1]  = '{1, 8'h10, 16'hE7BD, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[2]  = '{1, 8'h10, 16'h1234, 4'hE, 1, 1, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[3]  = '{1, 8'h10, 16'h1234, 4'hE, 1, 1, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[4]  = '{1, 8'h10, 16'h1234, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 6'd4};
    tbl[5]  = '{1, 8'h10, 16'h1234, 4'hE, 1, 0, 0, 0, 2'd1, 3'd0, 6'd4};
    tbl[6]  = '{1, 8'h10, 16'h0000, 4'h7, 1, 0, 0, 0, 2'd2, 3'd0, 6'd4};
    tbl[7]  = '{1, 8'h10, 16'h0000, 4'hB, 1, 0, 0, 0, 2'd3, 3'd0, 6'd4};
    tbl[8]  = '{1, 8'h10, 16'h0000, 4'hD, 1, 0, 1, 1, 2'd0, 3'd0, 6'd4};
    tbl[9]  = '{1, 8'h10, 16'h0000, 4'h0, 0, 0, 0, 1, 2'd0, 3'd0, 6'd4};
    tbl[10] = '{1, 8'h00, 16'h0000, 4'h0, 0, 0, 0, 1, 2'd0, 3'd0, 6'd0};
    tbl[11] = '{1, 8'h10, 16'hE7BD, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[12] = '{1, 8'h10, 16'h0000, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[13] = '{1, 8'h10, 16'h0000, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 6'd0};
    tbl[14] = '{1, 8'h10, 16'h0000, 4'h0, 0, 1, 0, 0, 2'd0, 3'd0, 6'd4};
    tbl[15] = '{1, 8'h10, 16'h0000, 4'hE, 1, 0, 0, 0, 2'd1, 3'd0, 6'd4};
    tbl[16] = '{1, 8'h10, 16'h0000, 4'h7, 1, 0, 0, 0, 2'd2, 3'd0, 6'd4};
    tbl[17] = '{1, 8'h10, 16'h0000, 4'hD, 1, 0, 0, 0, 2'd3, 3'd1, 6'd4};
    tbl[18] = '{1, 8'h10, 16'h0000, 4'hD, 1, 0, 1, 0, 2'd0, 3'd1, 6'd4};
    tbl[19] = '{1, 8'h00, 16'h0000, 4'h0, 0, 0, 0, 0, 2'd0, 3'd0, 6'd0};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].g, tbl[i].sq, tbl[i].c, tbl[i].b, tbl[i].o);
      chk_all($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].ed, tbl[i].em, tbl[i].es);
    end

    // Timeout after two digits
    arm(16'hE7BD);
    step(1, 8'h10, 16'h0, 4'hE, 1, 0);
    step(1, 8'h10, 16'h0, 4'h7, 1, 0);
    for (int i = 0; i < LIM - 1; i++) step(1, 8'h10, 16'h0, 4'h0, 0, 1);
    chk_all("to_pre", 0, 0, 2, 0, 1);
    step(1, 8'h10, 16'h0, 4'h0, 0, 1);
    chk_all("to", 1, 0, 2, 0, 0);
    step(1, 8'h10, 16'h0, 4'h0, 0, 0);
    chk("to_pulse", int'(bus.result_valid), 0);
    step(1, 8'h00, 16'h0, 4'h0, 0, 0);

    // Last digit and expiring second together
    arm(16'hE7BD);
    for (int i = 0; i < LIM - 1; i++) step(1, 8'h10, 16'h0, 4'h0, 0, 1);
    step(1, 8'h10, 16'h0, 4'hE, 1, 0);
    step(1, 8'h10, 16'h0, 4'h7, 1, 0);
    step(1, 8'h10, 16'h0, 4'hB, 1, 0);
    chk("sim_secs", int'(bus.secs_left), 1);
    step(1, 8'h10, 16'h0, 4'hD, 1, 1);
    chk("sim.valid", int'(bus.result_valid), 1);
    chk("sim.pass", int'(bus.result_pass), 1);
    chk("sim.mm", int'(bus.mismatch_count), 0);
    step(1, 8'h00, 16'h0, 4'h0, 0, 0);

    // Abort mid-collect
    arm(16'hE7BD);
    step(1, 8'h10, 16'h0, 4'hE, 1, 0);
    step(1, 8'h10, 16'h0, 4'h0, 1, 0);
    chk("ab_pre.mm", int'(bus.mismatch_count), 1);
    step(1, 8'h20, 16'h0, 4'h0, 0, 0);
    chk_all("ab", 0, 0, 0, 0, 0);
    step(1, 8'h20, 16'h0, 4'h0, 0, 0);
    chk("ab_post.valid", int'(bus.result_valid), 0);

    // Reset while in DONE
    arm(16'hE7BD);
    step(1, 8'h10, 16'h0, 4'hE, 1, 0);
    step(1, 8'h10, 16'h0, 4'h7, 1, 0);
    step(1, 8'h10, 16'h0, 4'hB, 1, 0);
    step(1, 8'h10, 16'h0, 4'hD, 1, 0);
    chk("rd_pre.pass", int'(bus.result_pass), 1);
    step(0, 8'h10, 16'h0, 4'h0, 0, 0);
    chk_all("rd", 0, 0, 0, 0, 0);
    step(1, 8'h00, 16'h0, 4'h0, 0, 0);

    // Randomized sessions against an event-list model
    for (int sess = 0; sess < 8; sess++) begin
      logic [15:0] tgt;
      int s_end, osn, k;
      int t_dig, t_to, nb, no, done_t;
      int e_pass, e_mm, e_dig, e_secs;
      bit miss[4];
      tgt = 16'($urandom);
      s_end = -1; osn = 0; k = 0;
      for (int i = 0; i < N; i++) begin
        if (i == 0) begin
          osa[i] = 0; bna[i] = 0; uca[i] = 4'h0;
        end else begin
          osa[i] = ($urandom_range(0, 3) == 0);
          bna[i] = ($urandom_range(0, 4) == 0);
          uca[i] = ($urandom_range(0, 1) == 1) ? nib(tgt, k % 4) : 4'($urandom);
          if (s_end >= 0 && bna[i]) k++;
          if (osa[i] && s_end < 0) begin
            osn++;
            if (osn == SHOW) s_end = i;
          end
        end
      end

      // Model: find 4th collect button and LIM-th collect second
      t_dig = N + 10; t_to = N + 10; nb = 0; no = 0;
      for (int j = 0; j < 4; j++) miss[j] = 0;
      if (s_end >= 0) begin
        for (int i = s_end + 1; i < N; i++) begin
          if (bna[i] && nb < 4) begin
            miss[nb] = (uca[i] != nib(tgt, nb));
            nb++;
            if (nb == 4 && t_dig > N) t_dig = i;
          end
          if (osa[i]) begin
            no++;
            if (no == LIM && t_to > N) t_to = i;
          end
        end
      end
      done_t = (t_dig <= t_to) ? t_dig : t_to;
      e_pass = 0; e_mm = 0; e_dig = 0; e_secs = 0;
      if (done_t < N) begin
        int cb, cs;
        cb = 0; cs = 0;
        for (int i = s_end + 1; i <= done_t; i++) begin
          if (bna[i]) cb++;
          if (osa[i]) cs++;
        end
        for (int j = 0; j < cb && j < 4; j++) e_mm += miss[j];
        e_dig = cb % 4;
        if (t_dig <= t_to) begin
          e_pass = (e_mm == 0);
          e_secs = LIM - cs;
        end
      end

      for (int i = 0; i < N; i++) begin
        step(1, 8'h10, (i == 0) ? tgt : 16'($urandom), uca[i], bna[i], osa[i]);
        chk($sformatf("rnd%0d.valid@%0d", sess, i), int'(bus.result_valid), int'(i == done_t));
        if (i == done_t) begin
          chk($sformatf("rnd%0d.pass", sess), int'(bus.result_pass), e_pass);
          chk($sformatf("rnd%0d.mm", sess), int'(bus.mismatch_count), e_mm);
          chk($sformatf("rnd%0d.digit", sess), int'(bus.digit_index), e_dig);
          chk($sformatf("rnd%0d.secs", sess), int'(bus.secs_left), e_secs);
        end
      end
      step(1, 8'h00, 16'h0, 4'h0, 0, 0);
      chk($sformatf("rnd%0d.hold", sess), int'(bus.result_pass), (done_t < N) ? e_pass : 0);
      chk($sformatf("rnd%0d.idle_valid", sess), int'(bus.result_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
